// File: rtl/run_ctrl_defs.sv
// Shared definitions for the run controller: state encoding and default sizing.
package run_ctrl_defs;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_MAX_CYC = 5000;
  localparam int PROG_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIN  = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  // Both terminal states produce the single-cycle run_done pulse.
  function automatic logic ends_run(input state_t s);
    return (s == ST_FIN) || (s == ST_TMO);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host and core signals of the run controller; master is the controller side.
interface run_ctrl_if
  import run_ctrl_defs::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic              go;
  logic [PROG_W-1:0] prog_sel;
  logic              core_done;
  logic              core_rst;
  logic              core_start;
  logic [PROG_W-1:0] prog_id;
  logic              busy;
  logic              run_done;
  logic              timeout;
  logic [CNT_W-1:0]  cycles;

  modport master (
    input  go, prog_sel, core_done,
    output core_rst, core_start, prog_id, busy, run_done, timeout, cycles
  );

  modport slave (
    output go, prog_sel, core_done,
    input  core_rst, core_start, prog_id, busy, run_done, timeout, cycles
  );

endinterface

// File: rtl/run_ctrl.sv
// Launches a program on the core: reset hold, timed run, completion or timeout report.
module run_ctrl
  import run_ctrl_defs::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int MAX_CYC = DEF_MAX_CYC
) (
  input  logic       clk,
  input  logic       rst,
  run_ctrl_if.master bus
);

  localparam logic [3:0]       HOLD_LOAD = 4'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_LIM   = CNT_W'(MAX_CYC);

  state_t            state_reg, state_next;
  logic [3:0]        hold_cnt_reg, hold_cnt_next;
  logic [CNT_W-1:0]  cycles_reg, cycles_next;
  logic [PROG_W-1:0] prog_id_reg, prog_id_next;
  logic              timeout_reg, timeout_next;
  logic              core_rst_reg, core_rst_next;
  logic              core_start_reg, core_start_next;
  logic              busy_reg, busy_next;
  logic              run_done_reg, run_done_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      hold_cnt_reg   <= '0;
      cycles_reg     <= '0;
      prog_id_reg    <= '0;
      timeout_reg    <= 1'b0;
      core_rst_reg   <= 1'b1;
      core_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      run_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      cycles_reg     <= cycles_next;
      prog_id_reg    <= prog_id_next;
      timeout_reg    <= timeout_next;
      core_rst_reg   <= core_rst_next;
      core_start_reg <= core_start_next;
      busy_reg       <= busy_next;
      run_done_reg   <= run_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    cycles_next     = cycles_reg;
    prog_id_next    = prog_id_reg;
    timeout_next    = timeout_reg;
    core_rst_next   = core_rst_reg;
    core_start_next = 1'b0;
    busy_next       = 1'b1;
    run_done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.go) begin
          state_next    = ST_HOLD;
          prog_id_next  = bus.prog_sel;
          timeout_next  = 1'b0;
          cycles_next   = '0;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_reg == 4'd0) begin
          state_next  = ST_RUN;
          cycles_next = CNT_W'(1);
        end else begin
          hold_cnt_next = hold_cnt_reg - 4'd1;
        end
      end
      ST_RUN: begin
        // Completion wins over the limit when both land on the same cycle.
        if (bus.core_done) begin
          state_next = ST_FIN;
        end else if (cycles_reg == MAX_LIM) begin
          state_next = ST_TMO;
        end else begin
          cycles_next = cycles_reg + CNT_W'(1);
        end
      end
      ST_FIN, ST_TMO: state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_next)
      ST_IDLE: busy_next = 1'b0;
      ST_HOLD: core_rst_next = 1'b1;
      ST_RUN: begin
        core_rst_next   = 1'b0;
        core_start_next = 1'b1;
      end
      ST_FIN:  core_rst_next = 1'b0;
      ST_TMO: begin
        core_rst_next = 1'b1;
        timeout_next  = 1'b1;
      end
      default: busy_next = 1'b0;
    endcase
    run_done_next = ends_run(state_next);
  end

  assign bus.core_rst   = core_rst_reg;
  assign bus.core_start = core_start_reg;
  assign bus.prog_id    = prog_id_reg;
  assign bus.busy       = busy_reg;
  assign bus.run_done   = run_done_reg;
  assign bus.timeout    = timeout_reg;
  assign bus.cycles     = cycles_reg;

endmodule
